ram_loader: RTL

- Upstream programming stage for the 16x8 DFF scratch RAM (addr/data_in/lr_n/ce_n/data_out interface).
- After a start pulse it accepts RAM_BYTES bytes over a valid/ready stream and writes them to consecutive addresses from 0.
- It then reads every location back and compares an 8-bit additive checksum. It reports done/error and then releases the RAM bus to the CPU side.

---
 rtl/ram_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Loads RAM_BYTES streamed bytes into the scratch RAM, then reads them back
// and compares an additive checksum before releasing the RAM bus.
module ram_loader #(
   parameter int RAM_BYTES = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_lr_n,
   output logic              mem_ce_n,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_BYTES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [7:0]        vsum_q, vsum_d;
   logic              vprime_q, vprime_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        data_d;
   logic              lr_d, ce_d;
   logic              busy_d, done_d, err_d;
   logic [7:0]        cks_d;

   assign in_ready = (state_q == LOAD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         vsum_q   <= '0;
         vprime_q <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_lr_n <= 1'b1;
         mem_ce_n <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         checksum <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         vsum_q   <= vsum_d;
         vprime_q <= vprime_d;
         mem_addr <= addr_d;
         mem_data <= data_d;
         mem_lr_n <= lr_d;
         mem_ce_n <= ce_d;
         busy     <= busy_d;
         done     <= done_d;
         error    <= err_d;
         checksum <= cks_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      vsum_d   = vsum_q;
      vprime_d = vprime_q;
      addr_d   = mem_addr;
      data_d   = mem_data;
      lr_d     = mem_lr_n;
      ce_d     = mem_ce_n;
      busy_d   = busy;
      done_d   = done;
      err_d    = error;
      cks_d    = checksum;
      unique case (state_q)
         IDLE: begin
            lr_d = 1'b1;
            ce_d = 1'b1;
            if (start) begin
               state_d  = LOAD;
               wr_cnt_d = '0;
               cks_d    = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
               busy_d   = 1'b1;
            end
         end
         LOAD: begin
            if (in_valid) begin
               addr_d   = wr_cnt_q;
               data_d   = in_data;
               lr_d     = 1'b0;
               cks_d    = checksum + in_data;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LAST) begin
                  state_d  = VERIFY;
                  vprime_d = 1'b1;
               end
            end else begin
               lr_d = 1'b1;
            end
         end
         VERIFY: begin
            // first cycle lets the RAM finish the final write
            if (vprime_q) begin
               vprime_d = 1'b0;
               lr_d     = 1'b1;
               ce_d     = 1'b0;
               addr_d   = '0;
               rd_cnt_d = '0;
               vsum_d   = '0;
            end else begin
               vsum_d   = vsum_q + mem_rdata;
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LAST) begin
                  ce_d    = 1'b1;
                  addr_d  = '0;
                  state_d = DONE;
               end else begin
                  addr_d = rd_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = (vsum_q != checksum);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
